game_round_ctrl: RTL and testbench
==================================

# game_round_ctrl

Parametrised round sequencer for the VGA arithmetic game. It replaces the free-running frame counter that used to pulse the RNGs. It runs a start / play / result / game-over state machine on the 25.1 MHz pixel clock and emits a one-cycle `new_round` pulse to retrigger the RNGs. It also counts down the per-round seconds timer shown by `two_digit_display`, and tracks score, lives and round number.

## Interface
Parameters:
- `CLK_HZ`, 25_125_000: clock cycles per one-second tick.
- `ROUND_SECS`, 30: countdown start value per round (1..99).
- `MAX_ROUNDS`, 10: rounds per game (1..127).
- `LIVES`, 3: wrong or timed-out answers allowed before game over (1..7).
- `RESULT_CYCLES`, 12_562_500: cycles the result state is held.

Ports:
- Clock and reset:
  - `clk`  in  1: pixel clock (PLL output). One clock only.
  - `rst`  in  1: asynchronous, active-high reset.
- Player inputs:
  - `start`  in  1: level input, sampled per cycle; begins or restarts a game.
  - `answer_valid`  in  1: one-cycle pulse, answer submitted.
  - `answer_correct`  in  1: qualifies `answer_valid`.
- RNG trigger and display values:
  - `new_round`  out  1: one-cycle pulse, wired to the RNG `trigger`.
  - `time_left`  out  7: seconds remaining (0..ROUND_SECS).
  - `score`  out  8: saturating at 255.
  - `lives`  out  3: lives remaining.
  - `round_idx`  out  7: current round, 1-based (0 in IDLE).
- Status flags:
  - `playing`  out  1: high in PLAY.
  - `result_ok`, `result_bad`  out  1 each: high throughout RESULT for a correct / wrong-or-timeout outcome.
  - `game_over`  out  1: high in OVER.

## Operation
- States are IDLE, LOAD, PLAY, RESULT and OVER. Reset enters IDLE.
- IDLE:
  - `start`=1 → LOAD.
  - Clears score, sets lives=LIVES and round_idx=0.
- LOAD (exactly one cycle):
  - `new_round`=1.
  - round_idx+=1, time_left=ROUND_SECS, prescaler=0.
  - → PLAY.
- PLAY:
  - The prescaler counts 0..CLK_HZ-1; at wrap, time_left decrements.
  - `answer_valid`=1 → RESULT. If `answer_correct`, score increments; otherwise lives decrements.
  - A tick with time_left==1 takes time_left to 0 → RESULT with timeout. Timeout is treated as wrong: lives decrements and `result_bad` is set.
  - An answer in the same cycle as the final tick takes priority over the timeout; time_left still goes to 0.
- RESULT:
  - Holds for RESULT_CYCLES cycles; time_left is frozen.
  - `answer_valid` is ignored.
  - Afterwards: lives==0 or round_idx==MAX_ROUNDS → OVER; else → LOAD.
- OVER:
  - All counters hold their values.
  - `start`=1 → LOAD, with score cleared, lives=LIVES and round_idx=0 before the LOAD increment.
- `start` is ignored in LOAD, PLAY and RESULT.
- Arithmetic rules:
  - Score adds saturate at 255.
  - Lives never go below 0.
  - The prescaler is sized to ceil(log2(CLK_HZ)), and the RESULT counter to ceil(log2(RESULT_CYCLES)).

## Timing
- All outputs are registered.
- Reset values: new_round=0, time_left=0, score=0, lives=LIVES, round_idx=0, playing=0, result_ok=0, result_bad=0, game_over=0.
- `start` high at edge N → LOAD at N+1; `new_round` high N+1..N+2 for exactly one cycle; `playing` high from N+2.
- Each tick: the first decrement occurs CLK_HZ cycles after entering PLAY.
- `answer_valid` at edge N:
  - score and lives update at N+1;
  - `result_ok`/`result_bad` go high at N+1 and stay high RESULT_CYCLES cycles;
  - next `new_round` or `game_over` follows on the cycle after.
- `rst` asserted mid-round clears everything asynchronously to the reset values. No `new_round` pulse is issued until a fresh `start` is received.

## Configuration
- `GAME_ROUND_CTRL_SPEED_BONUS_EN`:
  - Defined: a correct answer with time_left ≥ ceil(ROUND_SECS/2) at the answer cycle adds 2 to score (saturating). Otherwise it adds 1.
  - Undefined: every correct answer adds exactly 1, and the compare logic is absent.

## Test plan
All tests use CLK_HZ=4, ROUND_SECS=3, MAX_ROUNDS=3, LIVES=2, RESULT_CYCLES=2.
- Reset, then one start pulse → exactly one `new_round` pulse, time_left=3, round_idx=1, playing=1.
- No answer → time_left steps 3,2,1,0 every 4 cycles, then result_bad=1 for 2 cycles, lives=1, then a second `new_round`.
- A correct answer at time_left=3 → score=1 with the macro undefined, 2 with it defined; result_ok for 2 cycles.
- Two wrong answers → lives=0, then game_over=1. Later start → score=0, lives=2, round_idx=1, one `new_round`.
- Three correct rounds → game_over after round 3 with score=3 (macro undefined). An answer coincident with the final tick counts as correct.
- rst asserted during PLAY → all outputs at reset values immediately. No `new_round` appears without a new start.

Source files
------------

// File: rtl/game_round_ctrl.sv
// Round sequencer for the VGA arithmetic game: IDLE/LOAD/PLAY/RESULT/OVER.
// Optional macro GAME_ROUND_CTRL_SPEED_BONUS_EN: fast correct answers score 2.
module game_round_ctrl #(
    parameter int CLK_HZ        = 25_125_000,
    parameter int ROUND_SECS    = 30,
    parameter int MAX_ROUNDS    = 10,
    parameter int LIVES         = 3,
    parameter int RESULT_CYCLES = 12_562_500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       answer_valid,
    input  logic       answer_correct,
    output logic       new_round,
    output logic [6:0] time_left,
    output logic [7:0] score,
    output logic [2:0] lives,
    output logic [6:0] round_idx,
    output logic       playing,
    output logic       result_ok,
    output logic       result_bad,
    output logic       game_over
);

    localparam int PRE_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int RES_W = (RESULT_CYCLES > 1) ? $clog2(RESULT_CYCLES) : 1;

    localparam logic [PRE_W-1:0] PRE_LAST   = PRE_W'(CLK_HZ - 1);
    localparam logic [RES_W-1:0] RES_LAST   = RES_W'(RESULT_CYCLES - 1);
    localparam logic [6:0]       SECS       = 7'(ROUND_SECS);
    localparam logic [6:0]       LAST_ROUND = 7'(MAX_ROUNDS);
    localparam logic [2:0]       LIVES_INIT = 3'(LIVES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_PLAY,
        S_RESULT,
        S_OVER
    } state_t;

    state_t           state;
    logic [PRE_W-1:0] pre_cnt;
    logic [RES_W-1:0] res_cnt;
    logic             tick;
    logic             game_done;
    logic [7:0]       score_inc;
    logic [8:0]       score_sum;
    logic [7:0]       score_add;
    logic [2:0]       lives_dec;

    assign tick      = (pre_cnt == PRE_LAST);
    assign game_done = (lives == 3'd0) || (round_idx == LAST_ROUND);

`ifdef GAME_ROUND_CTRL_SPEED_BONUS_EN
    localparam logic [6:0] HALF_SECS = 7'((ROUND_SECS + 1) / 2);
    assign score_inc = (time_left >= HALF_SECS) ? 8'd2 : 8'd1;
`else
    assign score_inc = 8'd1;
`endif

    assign score_sum = {1'b0, score} + {1'b0, score_inc};
    assign score_add = score_sum[8] ? 8'hff : score_sum[7:0];
    assign lives_dec = (lives == 3'd0) ? 3'd0 : lives - 3'd1;

    // The LOAD-state updates are applied on the edge entering LOAD so
    // round_idx/time_left are already valid while new_round is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            pre_cnt    <= '0;
            res_cnt    <= '0;
            new_round  <= 1'b0;
            time_left  <= '0;
            score      <= '0;
            lives      <= LIVES_INIT;
            round_idx  <= '0;
            playing    <= 1'b0;
            result_ok  <= 1'b0;
            result_bad <= 1'b0;
            game_over  <= 1'b0;
        end else begin
            new_round <= 1'b0;
            unique case (state)
                S_IDLE, S_OVER: begin
                    if (start) begin
                        state     <= S_LOAD;
                        new_round <= 1'b1;
                        game_over <= 1'b0;
                        score     <= '0;
                        lives     <= LIVES_INIT;
                        round_idx <= 7'd1;
                        time_left <= SECS;
                        pre_cnt   <= '0;
                    end else if (state == S_IDLE) begin
                        score     <= '0;
                        lives     <= LIVES_INIT;
                        round_idx <= '0;
                    end
                end
                S_LOAD: begin
                    state   <= S_PLAY;
                    playing <= 1'b1;
                end
                S_PLAY: begin
                    pre_cnt <= tick ? '0 : pre_cnt + PRE_W'(1);
                    if (tick && time_left != 7'd0)
                        time_left <= time_left - 7'd1;
                    // An answer on the final tick wins over the timeout.
                    if (answer_valid) begin
                        state      <= S_RESULT;
                        playing    <= 1'b0;
                        res_cnt    <= '0;
                        result_ok  <= answer_correct;
                        result_bad <= !answer_correct;
                        if (answer_correct)
                            score <= score_add;
                        else
                            lives <= lives_dec;
                    end else if (tick && time_left == 7'd1) begin
                        state      <= S_RESULT;
                        playing    <= 1'b0;
                        res_cnt    <= '0;
                        result_bad <= 1'b1;
                        lives      <= lives_dec;
                    end
                end
                S_RESULT: begin
                    if (res_cnt == RES_LAST) begin
                        result_ok  <= 1'b0;
                        result_bad <= 1'b0;
                        if (game_done) begin
                            state     <= S_OVER;
                            game_over <= 1'b1;
                        end else begin
                            state     <= S_LOAD;
                            new_round <= 1'b1;
                            round_idx <= round_idx + 7'd1;
                            time_left <= SECS;
                            pre_cnt   <= '0;
                        end
                    end else begin
                        res_cnt <= res_cnt + RES_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_game_round_ctrl.sv
// Scoreboard bench for game_round_ctrl: per-cycle stimulus rows carry
// the expected output snapshot and are popped after each clock edge.
module tb_game_round_ctrl;

    localparam int CLK_HZ        = 4;
    localparam int ROUND_SECS    = 3;
    localparam int MAX_ROUNDS    = 3;
    localparam int LIVES         = 2;
    localparam int RESULT_CYCLES = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       answer_valid = 1'b0;
    logic       answer_correct = 1'b0;
    logic       new_round;
    logic [6:0] time_left;
    logic [7:0] score;
    logic [2:0] lives;
    logic [6:0] round_idx;
    logic       playing;
    logic       result_ok;
    logic       result_bad;
    logic       game_over;

    typedef struct packed {
        logic       nr;
        logic [6:0] tl;
        logic [7:0] sc;
        logic [2:0] lv;
        logic [6:0] ri;
        logic       pl;
        logic       ok;
        logic       bad;
        logic       go;
    } snap_t;

    typedef struct packed {
        logic  rs;
        logic  st;
        logic  av;
        logic  ac;
        snap_t exp;
    } row_t;

    row_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    game_round_ctrl #(
        .CLK_HZ       (CLK_HZ),
        .ROUND_SECS   (ROUND_SECS),
        .MAX_ROUNDS   (MAX_ROUNDS),
        .LIVES        (LIVES),
        .RESULT_CYCLES(RESULT_CYCLES)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .answer_valid  (answer_valid),
        .answer_correct(answer_correct),
        .new_round     (new_round),
        .time_left     (time_left),
        .score         (score),
        .lives         (lives),
        .round_idx     (round_idx),
        .playing       (playing),
        .result_ok     (result_ok),
        .result_bad    (result_bad),
        .game_over     (game_over)
    );

    always #5 clk = ~clk;

    function automatic snap_t mk(input int nr, input int tl,
                                 input int sc, input int lv,
                                 input int ri, input int pl,
                                 input int ok, input int bad,
                                 input int go);
        snap_t s;
        s.nr  = 1'(nr);
        s.tl  = 7'(tl);
        s.sc  = 8'(sc);
        s.lv  = 3'(lv);
        s.ri  = 7'(ri);
        s.pl  = 1'(pl);
        s.ok  = 1'(ok);
        s.bad = 1'(bad);
        s.go  = 1'(go);
        return s;
    endfunction

    function automatic snap_t s_idle();
        return mk(0, 0, 0, LIVES, 0, 0, 0, 0, 0);
    endfunction
    function automatic snap_t s_load(input int tl, input int sc,
                                     input int lv, input int ri);
        return mk(1, tl, sc, lv, ri, 0, 0, 0, 0);
    endfunction
    function automatic snap_t s_play(input int tl, input int sc,
                                     input int lv, input int ri);
        return mk(0, tl, sc, lv, ri, 1, 0, 0, 0);
    endfunction
    function automatic snap_t s_ok(input int tl, input int sc,
                                   input int lv, input int ri);
        return mk(0, tl, sc, lv, ri, 0, 1, 0, 0);
    endfunction
    function automatic snap_t s_bad(input int tl, input int sc,
                                    input int lv, input int ri);
        return mk(0, tl, sc, lv, ri, 0, 0, 1, 0);
    endfunction
    function automatic snap_t s_over(input int tl, input int sc,
                                     input int lv, input int ri);
        return mk(0, tl, sc, lv, ri, 0, 0, 0, 1);
    endfunction

    // Score increment for a correct answer given time_left at that cycle.
    function automatic int bonus(input int tl);
`ifdef GAME_ROUND_CTRL_SPEED_BONUS_EN
        return (tl >= (ROUND_SECS + 1) / 2) ? 2 : 1;
`else
        return (tl >= 0) ? 1 : 1;
`endif
    endfunction

    function automatic snap_t cur();
        return {new_round, time_left, score, lives, round_idx,
                playing, result_ok, result_bad, game_over};
    endfunction

    function automatic string fmt(input snap_t s);
        return $sformatf(
            "nr=%0b tl=%0d sc=%0d lv=%0d ri=%0d pl=%0b ok=%0b bad=%0b go=%0b",
            s.nr, s.tl, s.sc, s.lv, s.ri, s.pl, s.ok, s.bad, s.go);
    endfunction

    task automatic push(input int rs, input int st, input int av,
                        input int ac, input snap_t e);
        row_t r;
        r.rs  = 1'(rs);
        r.st  = 1'(st);
        r.av  = 1'(av);
        r.ac  = 1'(ac);
        r.exp = e;
        sb.push_back(r);
    endtask

    task automatic test_reset();
        row_t  r;
        snap_t got;
        int    i = 0;
        repeat (2) push(1, 0, 0, 0, s_idle());
        repeat (3) push(0, 0, 0, 0, s_idle());
        while (sb.size() > 0) begin
            r = sb.pop_front();
            rst = r.rs; start = r.st;
            answer_valid = r.av; answer_correct = r.ac;
            @(negedge clk);
            got = cur();
            n_cmp++;
            if (got !== r.exp) begin
                n_bad++;
                $display("FAIL reset row %0d: got %s want %s",
                         i, fmt(got), fmt(r.exp));
            end
            i++;
        end
    endtask

    // start held high throughout: it must be ignored outside IDLE/OVER.
    task automatic test_start_timeout();
        row_t  r;
        snap_t got;
        int    i = 0;
        push(1, 0, 0, 0, s_idle());
        push(0, 1, 0, 0, s_load(3, 0, 2, 1));
        push(0, 1, 0, 0, s_play(3, 0, 2, 1));
        for (int t = 3; t >= 1; t--) begin
            repeat (3) push(0, 1, 0, 0, s_play(t, 0, 2, 1));
            if (t > 1)
                push(0, 1, 0, 0, s_play(t - 1, 0, 2, 1));
            else
                push(0, 1, 0, 0, s_bad(0, 0, 1, 1));
        end
        push(0, 1, 0, 0, s_bad(0, 0, 1, 1));
        push(0, 1, 0, 0, s_load(3, 0, 1, 2));
        push(0, 0, 0, 0, s_play(3, 0, 1, 2));
        while (sb.size() > 0) begin
            r = sb.pop_front();
            rst = r.rs; start = r.st;
            answer_valid = r.av; answer_correct = r.ac;
            @(negedge clk);
            got = cur();
            n_cmp++;
            if (got !== r.exp) begin
                n_bad++;
                $display("FAIL start_timeout row %0d: got %s want %s",
                         i, fmt(got), fmt(r.exp));
            end
            i++;
        end
    endtask

    // Correct answers at time_left 3, 1 and 2; answer during RESULT ignored.
    task automatic test_correct();
        row_t  r;
        snap_t got;
        int    i = 0;
        int    s1 = bonus(3);
        int    s2 = s1 + bonus(1);
        int    s3 = s2 + bonus(2);
        push(1, 0, 0, 0, s_idle());
        push(0, 1, 0, 0, s_load(3, 0, 2, 1));
        push(0, 0, 0, 0, s_play(3, 0, 2, 1));
        push(0, 0, 1, 1, s_ok(3, s1, 2, 1));
        push(0, 0, 1, 1, s_ok(3, s1, 2, 1));
        push(0, 0, 0, 0, s_load(3, s1, 2, 2));
        push(0, 0, 0, 0, s_play(3, s1, 2, 2));
        repeat (3) push(0, 0, 0, 0, s_play(3, s1, 2, 2));
        push(0, 0, 0, 0, s_play(2, s1, 2, 2));
        repeat (3) push(0, 0, 0, 0, s_play(2, s1, 2, 2));
        push(0, 0, 0, 0, s_play(1, s1, 2, 2));
        push(0, 0, 1, 1, s_ok(1, s2, 2, 2));
        push(0, 0, 0, 0, s_ok(1, s2, 2, 2));
        push(0, 0, 0, 0, s_load(3, s2, 2, 3));
        push(0, 0, 0, 0, s_play(3, s2, 2, 3));
        repeat (3) push(0, 0, 0, 0, s_play(3, s2, 2, 3));
        push(0, 0, 0, 0, s_play(2, s2, 2, 3));
        push(0, 0, 1, 1, s_ok(2, s3, 2, 3));
        push(0, 0, 0, 0, s_ok(2, s3, 2, 3));
        push(0, 0, 0, 0, s_over(2, s3, 2, 3));
        while (sb.size() > 0) begin
            r = sb.pop_front();
            rst = r.rs; start = r.st;
            answer_valid = r.av; answer_correct = r.ac;
            @(negedge clk);
            got = cur();
            n_cmp++;
            if (got !== r.exp) begin
                n_bad++;
                $display("FAIL correct row %0d: got %s want %s",
                         i, fmt(got), fmt(r.exp));
            end
            i++;
        end
    endtask

    task automatic test_wrong_over();
        row_t  r;
        snap_t got;
        int    i = 0;
        push(1, 0, 0, 0, s_idle());
        push(0, 1, 0, 0, s_load(3, 0, 2, 1));
        push(0, 0, 0, 0, s_play(3, 0, 2, 1));
        push(0, 0, 1, 0, s_bad(3, 0, 1, 1));
        push(0, 0, 1, 0, s_bad(3, 0, 1, 1));
        push(0, 0, 0, 0, s_load(3, 0, 1, 2));
        push(0, 0, 0, 0, s_play(3, 0, 1, 2));
        push(0, 0, 1, 0, s_bad(3, 0, 0, 2));
        push(0, 0, 0, 0, s_bad(3, 0, 0, 2));
        push(0, 0, 0, 0, s_over(3, 0, 0, 2));
        push(0, 0, 1, 1, s_over(3, 0, 0, 2));
        repeat (2) push(0, 0, 0, 0, s_over(3, 0, 0, 2));
        push(0, 1, 0, 0, s_load(3, 0, 2, 1));
        push(0, 0, 0, 0, s_play(3, 0, 2, 1));
        while (sb.size() > 0) begin
            r = sb.pop_front();
            rst = r.rs; start = r.st;
            answer_valid = r.av; answer_correct = r.ac;
            @(negedge clk);
            got = cur();
            n_cmp++;
            if (got !== r.exp) begin
                n_bad++;
                $display("FAIL wrong_over row %0d: got %s want %s",
                         i, fmt(got), fmt(r.exp));
            end
            i++;
        end
    endtask

    // Three correct rounds; the last answer lands on the final tick.
    task automatic test_back_to_back();
        row_t  r;
        snap_t got;
        int    i = 0;
        int    s1 = bonus(3);
        int    s2 = s1 + bonus(3);
        int    s3 = s2 + bonus(1);
        push(1, 0, 0, 0, s_idle());
        push(0, 1, 0, 0, s_load(3, 0, 2, 1));
        push(0, 0, 0, 0, s_play(3, 0, 2, 1));
        push(0, 0, 1, 1, s_ok(3, s1, 2, 1));
        push(0, 0, 0, 0, s_ok(3, s1, 2, 1));
        push(0, 0, 0, 0, s_load(3, s1, 2, 2));
        push(0, 0, 0, 0, s_play(3, s1, 2, 2));
        push(0, 0, 1, 1, s_ok(3, s2, 2, 2));
        push(0, 0, 0, 0, s_ok(3, s2, 2, 2));
        push(0, 0, 0, 0, s_load(3, s2, 2, 3));
        push(0, 0, 0, 0, s_play(3, s2, 2, 3));
        for (int t = 3; t >= 2; t--) begin
            repeat (3) push(0, 0, 0, 0, s_play(t, s2, 2, 3));
            push(0, 0, 0, 0, s_play(t - 1, s2, 2, 3));
        end
        repeat (3) push(0, 0, 0, 0, s_play(1, s2, 2, 3));
        push(0, 0, 1, 1, s_ok(0, s3, 2, 3));
        push(0, 0, 0, 0, s_ok(0, s3, 2, 3));
        push(0, 0, 0, 0, s_over(0, s3, 2, 3));
        while (sb.size() > 0) begin
            r = sb.pop_front();
            rst = r.rs; start = r.st;
            answer_valid = r.av; answer_correct = r.ac;
            @(negedge clk);
            got = cur();
            n_cmp++;
            if (got !== r.exp) begin
                n_bad++;
                $display("FAIL back_to_back row %0d: got %s want %s",
                         i, fmt(got), fmt(r.exp));
            end
            i++;
        end
    endtask

    task automatic test_rst_mid();
        row_t  r;
        snap_t got;
        int    i = 0;
        push(1, 0, 0, 0, s_idle());
        push(0, 1, 0, 0, s_load(3, 0, 2, 1));
        repeat (3) push(0, 0, 0, 0, s_play(3, 0, 2, 1));
        while (sb.size() > 0) begin
            r = sb.pop_front();
            rst = r.rs; start = r.st;
            answer_valid = r.av; answer_correct = r.ac;
            @(negedge clk);
            got = cur();
            n_cmp++;
            if (got !== r.exp) begin
                n_bad++;
                $display("FAIL rst_mid row %0d: got %s want %s",
                         i, fmt(got), fmt(r.exp));
            end
            i++;
        end
        // Reset between edges must clear outputs without a clock.
        push(1, 0, 0, 0, s_idle());
        #2;
        r = sb.pop_front();
        rst = r.rs;
        #1;
        got = cur();
        n_cmp++;
        if (got !== r.exp) begin
            n_bad++;
            $display("FAIL rst_async: got %s want %s",
                     fmt(got), fmt(r.exp));
        end
        push(1, 0, 0, 0, s_idle());
        repeat (8) push(0, 0, 0, 0, s_idle());
        while (sb.size() > 0) begin
            r = sb.pop_front();
            rst = r.rs; start = r.st;
            answer_valid = r.av; answer_correct = r.ac;
            @(negedge clk);
            got = cur();
            n_cmp++;
            if (got !== r.exp) begin
                n_bad++;
                $display("FAIL rst_after row %0d: got %s want %s",
                         i, fmt(got), fmt(r.exp));
            end
            i++;
        end
    endtask

    initial begin
        test_reset();
        test_start_timeout();
        test_correct();
        test_wrong_over();
        test_back_to_back();
        test_rst_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, limit 200000 ns");
        $fatal(1);
    end

endmodule
